uart_receiver: RTL and testbench
================================

# uart_receiver

Receives asynchronous serial frames from the FPGA-to-PC UART link (start bit, 8 data bits LSB first, even parity bit, stop bit) and presents each byte in a holding register. It consumes the line driven by `uart_transmitter` (loopback or the far end's transmitter). It drives `hold` back to that transmitter so no byte is sent while an unread byte is pending.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); minimum legal value 4.

Ports:
- `clock`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_in`  input  1  serial line; idles high.
- `read`  input  1  host acknowledges/consumes `data_out`.
- `data_out`  output  8  last received byte.
- `valid`  output  1  `data_out` holds an unread byte.
- `parity_error`  output  1  parity check result for the byte in `data_out`; valid while `valid`=1.
- `frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a frame completed while `valid`=1 and no `read` that cycle.
- `hold`  output  1  equals `valid`; wired to the transmitter's `hold`.

## Operation
- `data_in` passes through a 2-flop synchronizer, which presets to 1 on reset; all decisions use the synchronized value `rx`.
- Bit timer: counts 0..CLKS_PER_BIT-1 and restarts on each state entry.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `rx`=0 -> START, with the timer cleared.
- START: at timer = CLKS_PER_BIT/2 (integer division), sample `rx`.
  - `rx`=1 is a false start -> IDLE, with no output.
  - `rx`=0 -> DATA, with the bit index at 0.
- DATA: every CLKS_PER_BIT cycles, shift `rx` into bit [index] of the shift register (LSB first). After index 7 -> PARITY.
- PARITY: after CLKS_PER_BIT cycles, capture `rx` as bit p -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx` and return to IDLE.
  - Stop = 1 and (`valid`=0 or `read`=1): load `data_out` with the shift register, load `parity_error` with ^{byte,p}, and set `valid`=1.
  - Stop = 1 and `valid`=1 and `read`=0: pulse `overrun`; the old byte and its flags are kept; the new byte is dropped.
  - Stop = 0: pulse `frame_error`; the byte is dropped. IDLE re-arms only after `rx` returns to 1: a held-low break yields no further frames.
- Even parity: the byte plus its parity bit must contain an even number of ones, matching the transmitter's parity = XOR of the data bits.
- `read` with `valid`=1 clears `valid` on the next edge. `read` with `valid`=0 is ignored.
- A load and a `read` in the same cycle: the load wins, `valid` stays 1, and no overrun is flagged.

## Timing
- Reset values:
  - `data_out` = 8'h00
  - `valid`, `parity_error`, `frame_error`, `overrun`, `hold` = 0
  - state = IDLE, timer = 0, synchronizer = 1
- Reset asserted mid-frame aborts the frame immediately; no flags are produced.
- Input latency: 2 cycles through the synchronizer.
- Sampling is at mid-bit: each bit is sampled CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after the start edge is seen in `rx`.
- `valid` rises on the edge after the stop-bit sample: about 10.5·CLKS_PER_BIT + 3 cycles after the falling edge on `data_in`.
- `frame_error` and `overrun` are high for exactly one cycle, aligned with that edge.
- Back-to-back frames: a new start edge is accepted in the cycle after the STOP sample.

## Configuration
- `UART_RX_PARITY_EN` defined: the 11-bit frame described above.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 10 bits; the PARITY state is removed and DATA goes directly to STOP.
  - `parity_error` is tied to 0.
  - `valid` rises about 9.5·CLKS_PER_BIT + 3 cycles after the start edge.

## Test plan
All scenarios use CLKS_PER_BIT=16 and `UART_RX_PARITY_EN` defined unless stated.
- Frame 0xA5 with parity 0 and stop 1 -> `data_out`=0xA5, `valid`=1, `parity_error`=0, `hold`=1; `read` pulse -> `valid`=0 next cycle.
- Frame 0x01 with parity 0 (wrong) -> `data_out`=0x01, `parity_error`=1.
- Frame 0x3C with stop 0 -> one-cycle `frame_error`, `valid` stays 0; line held low 40 bits then released -> no further frames.
- Frames 0x11 then 0x22 back-to-back with no `read` -> `overrun` pulse at the second frame's stop, `data_out` remains 0x11. Repeat with `read` asserted in the load cycle -> `data_out`=0x22, `valid`=1, no `overrun`.
- `data_in` low pulse of 6 cycles -> false start, no outputs change. Reset asserted at bit 4 of a frame -> all outputs 0; the next clean 0x5A frame is received correctly.
- `UART_RX_PARITY_EN` undefined: 10-bit frame 0xC3 -> `data_out`=0xC3, `valid`=1, `parity_error`=0.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, one stop bit, mid-bit sampling, single holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    input  logic       read,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun,
    output logic       hold
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             rx;

    assign rx = sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], data_in};
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        brk_d   = brk_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (read && valid_q) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // After a framing error the line must go idle before a new start is trusted.
                if (brk_q) begin
                    if (rx) brk_d = 1'b0;
                end else if (!rx) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == HALF) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == LAST) begin
                    timer_d        = '0;
                    shreg_d[idx_q] = rx;
                    idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_q == LAST) begin
                    timer_d = '0;
                    par_d   = rx;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (timer_q == LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (!rx) begin
                        fe_d  = 1'b1;
                        brk_d = 1'b1;
                    end else if (valid_q && !read) begin
                        ov_d = 1'b1;
                    end else begin
                        // A load overrides a same-cycle read.
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shreg_q, par_q};
`else
                        perr_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out     = data_q;
    assign valid        = valid_q;
    assign hold         = valid_q;
    assign parity_error = perr_q;
    assign frame_error  = fe_q;
    assign overrun      = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a frame-level outcome model.
module tb_uart_receiver;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedge index (from the start-bit falling edge) whose following posedge samples the stop bit.
    localparam int LOAD_NE = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data_out;
    logic       valid, parity_error, frame_error, overrun, hold;

    int n_chk = 0, n_err = 0;
    int fe_seen = 0, ov_seen = 0;
    int exp_fe = 0, exp_ov = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_perr = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .read(read),
        .data_out(data_out), .valid(valid), .parity_error(parity_error),
        .frame_error(frame_error), .overrun(overrun), .hold(hold)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] b, input logic p);
`ifdef UART_RX_PARITY_EN
        return (($countones(b) + int'(p)) % 2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".data"}, 32'(data_out), 32'(m_data));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".hold"}, 32'(hold), 32'(m_valid));
        if (m_valid) chk({tag, ".perr"}, 32'(parity_error), 32'(m_perr));
        chk({tag, ".fe_cnt"}, 32'(fe_seen), 32'(exp_fe));
        chk({tag, ".ov_cnt"}, 32'(ov_seen), 32'(exp_ov));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            data_in = 1'b1;
            read = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stp, input logic rd);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9] = p;
        bits[10] = stp;
`else
        bits[9] = stp;
`endif
        for (int i = 0; i < NBITS * CPB; i++) begin
            @(negedge clock);
            data_in = bits[i / CPB];
            read = rd && (i == LOAD_NE);
        end
        if (!stp) begin
            exp_fe++;
            if (rd) m_valid = 1'b0;
        end else if (m_valid && !rd) begin
            exp_ov++;
        end else begin
            m_data = b;
            m_perr = exp_perr(b, p);
            m_valid = 1'b1;
        end
    endtask

    task automatic do_read();
        @(negedge clock);
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        m_valid = 1'b0;
        chk("read_clears_valid", 32'(valid), 32'(0));
    endtask

    initial begin
        logic [7:0] b;
        logic p, stp, rd;
        logic [10:0] bits;

        repeat (3) @(negedge clock);
        chk("rst.data", 32'(data_out), 32'(0));
        chk("rst.flags", 32'({valid, parity_error, frame_error, overrun, hold}), 32'(0));
        reset = 1'b1;
        idle(5);
        check_all("post_reset");

        // Correct parity, then read
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check_all("a5");
        do_read();
        check_all("a5_read");

        // Wrong parity
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check_all("01_badpar");
        do_read();

        // Framing error followed by a long break
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        check_all("3c_ferr");
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clock);
            data_in = 1'b0;
        end
        idle(2 * CPB);
        check_all("break");

        // Overrun, then same pair with read in the load cycle
        send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b1, 1'b0);
        check_all("overrun");
        do_read();
        send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b1, 1'b1);
        check_all("read_at_load");
        do_read();

        // False start
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            data_in = 1'b0;
        end
        idle(3 * CPB);
        check_all("false_start");

        // Reset in the middle of a frame
        send_frame(8'h77, ^8'h77, 1'b1, 1'b0);
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = 8'h96;
        for (int i = 0; i < 4 * CPB + CPB / 2; i++) begin
            @(negedge clock);
            data_in = bits[i / CPB];
        end
        reset = 1'b0;
        #1;
        m_data = 8'h00;
        m_valid = 1'b0;
        m_perr = 1'b0;
        check_all("midframe_reset");
        chk("midframe_reset.flags", 32'({parity_error, frame_error, overrun}), 32'(0));
        idle(3);
        reset = 1'b1;
        idle(4);
        send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0);
        check_all("5a_after_reset");
        do_read();

        // Random frames
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            p = (^b) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 2) == 0);
            send_frame(b, p, stp, rd);
            check_all($sformatf("rnd%0d", n));
            if (!stp) idle(4);
            else idle($urandom_range(0, 20));
            if (m_valid && $urandom_range(0, 2) == 0) do_read();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
